uart_receiver: RTL

- 8N1 UART receiver; the consumer stage directly downstream of uart_transmitter's tx line.
- Used on ICE40 for a loopback self-check of the transmitter.
- Oversamples the serial line with the same ClocksPerBaud divisor as the transmitter.
- Presents each received byte on a valid/done handshake, mirroring the transmitter's tx_byte/tx_byte_valid/tx_byte_done interface.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_synchronizer.sv | 30 +++
 rtl/uart_receiver.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - uart_state_e : frame FSM state encoding (IDLE/START/DATA/STOP, plus
//                    PARITY when UART_RECEIVER_PARITY_EN is defined)
//   - UartDataBits : data bits per frame
//   - counter_width: bit-clock counter width for a given ClocksPerBaud
// Optional feature macro: UART_RECEIVER_PARITY_EN (adds the PARITY state).
package uart_pkg;

  localparam int UartDataBits = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RECEIVER_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } uart_state_e;

  // The counter only has to hold ClocksPerBaud-1; never narrower than 1 bit.
  function automatic int counter_width(input int clocks_per_baud);
    if (clocks_per_baud <= 2) begin
      return 1;
    end
    return $clog2(clocks_per_baud);
  endfunction

endpackage

// File: rtl/uart_rx_synchronizer.sv
// uart_rx_synchronizer: two-flop synchronizer for an asynchronous input.
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset; both flops load ResetValue
//   async_i : asynchronous input
//   sync_o  : input re-timed to clk, two cycles of latency
module uart_rx_synchronizer #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver (8E1 with UART_RECEIVER_PARITY_EN).
//   clk              : sole clock
//   rst_n            : asynchronous active-low reset
//   rx_in            : serial line, idle high, asynchronous to clk
//   rx_byte          : received byte, stable while rx_byte_valid is high
//   rx_byte_valid    : byte available, held until rx_byte_done
//   rx_byte_done     : consumer pulse, consumes the byte while valid
//   rx_framing_error : one-cycle pulse on a bad stop (or parity) bit
//   rx_overrun       : sticky, a byte completed while the previous was unread
// Optional feature macro: UART_RECEIVER_PARITY_EN (even parity bit between
// the data bits and the stop bit).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int ClocksPerBaud = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_in,
  output logic [UartDataBits-1:0] rx_byte,
  output logic                    rx_byte_valid,
  input  logic                    rx_byte_done,
  output logic                    rx_framing_error,
  output logic                    rx_overrun
);

  localparam int CntW = counter_width(ClocksPerBaud);
  localparam logic [CntW-1:0] HalfLoad = CntW'(ClocksPerBaud / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(ClocksPerBaud - 1);

  logic rx_s;

  uart_rx_synchronizer #(
    .ResetValue(1'b1)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(rx_in),
    .sync_o (rx_s)
  );

  uart_state_e             state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [UartDataBits-1:0] shift_q, shift_d;
  logic [UartDataBits-1:0] rx_byte_q, rx_byte_d;
  logic                    valid_q, valid_d;
  logic                    fe_q, fe_d;
  logic                    ovr_q, ovr_d;
`ifdef UART_RECEIVER_PARITY_EN
  logic                    par_bad_q, par_bad_d;
`endif

  logic consume;
  logic expired;
  logic frame_bad;

  assign consume = valid_q && rx_byte_done;
  assign expired = (cnt_q == '0);
`ifdef UART_RECEIVER_PARITY_EN
  assign frame_bad = !rx_s || par_bad_q;
`else
  assign frame_bad = !rx_s;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_byte_d = rx_byte_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ovr_d     = ovr_q;
`ifdef UART_RECEIVER_PARITY_EN
    par_bad_d = par_bad_q;
`endif

    // Consuming the byte also clears a pending overrun; a STOP completion in
    // the same cycle below may immediately refill the output register.
    if (consume) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = HalfLoad;
          state_d = START;
        end
      end
      START: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          cnt_d     = FullLoad;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          state_d = IDLE;  // start bit gone by mid-bit: treat as a glitch
        end
      end
      DATA: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d[bit_idx_q] = rx_s;
          cnt_d              = FullLoad;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RECEIVER_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RECEIVER_PARITY_EN
      PARITY: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Even parity: data bits plus parity bit must XOR to zero.
          par_bad_d = (^shift_q) ^ rx_s;
          cnt_d     = FullLoad;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (!expired) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          if (frame_bad) begin
            fe_d = 1'b1;
          end else if (!valid_q || consume) begin
            rx_byte_d = shift_q;
            valid_d   = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_byte_q <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_byte_q <= rx_byte_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
`ifdef UART_RECEIVER_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign rx_byte          = rx_byte_q;
  assign rx_byte_valid    = valid_q;
  assign rx_framing_error = fe_q;
  assign rx_overrun       = ovr_q;

endmodule
